// File: rtl/twiddle_seq_gen.sv
// rtl/twiddle_seq_gen.sv - streaming radix-2 DIT twiddle generator for one FFT stage
module twiddle_seq_gen #(
    parameter int TWID_WIDTH = 16,
    parameter int LOG2N      = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(LOG2N)-1:0]     stage,
    input  logic                         inverse,
    output logic                         tw_valid,
    input  logic                         tw_ready,
    output logic signed [TWID_WIDTH-1:0] tw_cos,
    output logic signed [TWID_WIDTH-1:0] tw_sin,
    output logic [LOG2N-2:0]             tw_k,
    output logic                         tw_last,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int SW  = $clog2(LOG2N);
    localparam int KW  = LOG2N - 1;
    localparam int Q4N = 1 << (LOG2N - 2);
    localparam logic [KW-1:0] Q4        = KW'(Q4N);
    localparam logic [KW-1:0] CNT_MAX   = {KW{1'b1}};
    localparam logic [SW-1:0] TOP_STAGE = SW'(LOG2N - 1);
    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = (2.0 ** (TWID_WIDTH - 1)) - 1.0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // Quarter-wave cosine table, Q[i] = round(AMP * cos(2*pi*i/N)), built at elaboration.
    logic signed [TWID_WIDTH-1:0] q_rom [0:Q4N];
    for (genvar i = 0; i <= Q4N; i++) begin : g_rom
        localparam real ANG = 2.0 * PI * i / (2.0 ** LOG2N);
        localparam int  QV  = $rtoi(AMP * $cos(ANG) + 0.5);
        assign q_rom[i] = TWID_WIDTH'(QV);
    end

    state_t                       state_q, state_d;
    logic [KW-1:0]                cnt_q, cnt_d;
    logic [SW-1:0]                stage_q, stage_d;
    logic                         inv_q, inv_d;
    logic                         v1_q, v1_d;
    logic [KW-1:0]                k1_q, k1_d;
    logic                         last1_q, last1_d;
    logic                         valid_q, valid_d;
    logic signed [TWID_WIDTH-1:0] cos_q, cos_d;
    logic signed [TWID_WIDTH-1:0] sin_q, sin_d;
    logic [KW-1:0]                k_q, k_d;
    logic                         last_q, last_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;

    logic                         en;
    logic [KW-1:0]                mask;
    logic [KW-1:0]                k_issue;
    logic [KW-1:0]                c_idx;
    logic [KW-1:0]                s_idx;
    logic                         c_neg;
    logic signed [TWID_WIDTH-1:0] c_raw;
    logic signed [TWID_WIDTH-1:0] s_raw;

    // Exponent of the running word: butterfly index b = cnt mod 2^s scaled by 2^(LOG2N-1-s).
    always_comb begin
        mask    = (KW'(1) << stage_q) - KW'(1);
        k_issue = (cnt_q & mask) << (TOP_STAGE - stage_q);
    end

    // Fold k onto the quarter-wave table and pick the cosine sign.
    always_comb begin
        c_idx = k1_q;
        s_idx = Q4 - k1_q;
        c_neg = 1'b0;
        if (k1_q > Q4) begin
            c_idx = KW'(0) - k1_q;
            s_idx = k1_q - Q4;
            c_neg = 1'b1;
        end
        c_raw = q_rom[c_idx];
        s_raw = q_rom[s_idx];
    end

    // Control FSM plus both pipeline stages; everything advances only on the global enable.
    always_comb begin
        en      = !valid_q || tw_ready;
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        inv_d   = inv_q;
        v1_d    = v1_q;
        k1_d    = k1_q;
        last1_d = last1_q;
        valid_d = valid_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        k_d     = k_q;
        last_d  = last_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (32'(stage) < LOG2N) begin
                        state_d = RUN;
                        stage_d = stage;
                        inv_d   = inverse;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (en) begin
                    cnt_d = cnt_q + KW'(1);
                    if (cnt_q == CNT_MAX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (valid_q && tw_ready && last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (en) begin
            v1_d    = (state_q == RUN);
            k1_d    = k_issue;
            last1_d = (state_q == RUN) && (cnt_q == CNT_MAX);
            valid_d = v1_q;
            last_d  = v1_q && last1_q;
            if (v1_q) begin
                k_d   = k1_q;
                cos_d = c_neg ? -c_raw : c_raw;
                sin_d = inv_q ? s_raw : -s_raw;
            end
        end
    end

    // State and pipeline registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
            v1_q    <= 1'b0;
            k1_q    <= '0;
            last1_q <= 1'b0;
            valid_q <= 1'b0;
            cos_q   <= '0;
            sin_q   <= '0;
            k_q     <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            inv_q   <= inv_d;
            v1_q    <= v1_d;
            k1_q    <= k1_d;
            last1_q <= last1_d;
            valid_q <= valid_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            k_q     <= k_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tw_valid = valid_q;
    assign tw_cos   = cos_q;
    assign tw_sin   = sin_q;
    assign tw_k     = k_q;
    assign tw_last  = last_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_twiddle_seq_gen.sv
// tb/tb_twiddle_seq_gen.sv - directed self-checking bench for twiddle_seq_gen at N=8
module tb_twiddle_seq_gen;
    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               start    = 1'b0;
    logic [1:0]         stage    = 2'd0;
    logic               inverse  = 1'b0;
    logic               tw_ready = 1'b1;
    logic               tw_valid;
    logic signed [15:0] tw_cos;
    logic signed [15:0] tw_sin;
    logic [1:0]         tw_k;
    logic               tw_last;
    logic               busy;
    logic               done;
    logic               err;

    int checks = 0;
    int errors = 0;

    int got_n;
    bit got_done;
    int got_k    [8];
    int got_cos  [8];
    int got_sin  [8];
    int got_last [8];

    int COS_T [4]    = '{32767, 23170, 0, -23170};
    int SIN_T [4]    = '{0, -23170, -32767, -23170};
    int K_T   [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};
    bit RDY_T [4]    = '{1'b1, 1'b0, 1'b0, 1'b1};

    twiddle_seq_gen #(
        .TWID_WIDTH (16),
        .LOG2N      (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stage    (stage),
        .inverse  (inverse),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .tw_cos   (tw_cos),
        .tw_sin   (tw_sin),
        .tw_k     (tw_k),
        .tw_last  (tw_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_seq(input logic [1:0] st, input logic inv, input bit toggle, input int inject_at);
        bit stalled;
        int ref_k;
        int ref_cos;
        int ref_sin;
        got_n    = 0;
        got_done = 1'b0;
        stalled  = 1'b0;
        ref_k    = 0;
        ref_cos  = 0;
        ref_sin  = 0;
        @(negedge clk);
        start    = 1'b1;
        stage    = st;
        inverse  = inv;
        tw_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 80 && !got_done; cyc++) begin
            tw_ready = toggle ? RDY_T[cyc % 4] : 1'b1;
            start    = (cyc == inject_at);
            if (cyc == inject_at) stage = 2'd0;
            if (stalled) begin
                chk("hold_valid", tw_valid, 1);
                chk("hold_k", tw_k, ref_k);
                chk("hold_cos", tw_cos, ref_cos);
                chk("hold_sin", tw_sin, ref_sin);
            end
            stalled = tw_valid && !tw_ready;
            ref_k   = tw_k;
            ref_cos = tw_cos;
            ref_sin = tw_sin;
            if (done) begin
                got_done = 1'b1;
            end else if (tw_valid && tw_ready) begin
                if (got_n < 8) begin
                    got_k[got_n]    = tw_k;
                    got_cos[got_n]  = tw_cos;
                    got_sin[got_n]  = tw_sin;
                    got_last[got_n] = tw_last;
                end
                got_n++;
            end
            if (!got_done) @(negedge clk);
        end
        start    = 1'b0;
        tw_ready = 1'b1;
        chk("done_seen", got_done, 1);
    endtask

    task automatic check_seq(input string tag, input int st, input bit inv);
        chk($sformatf("%s_count", tag), got_n, 4);
        for (int i = 0; i < 4 && i < got_n; i++) begin
            int k;
            k = K_T[st][i];
            chk($sformatf("%s_k%0d", tag, i), got_k[i], k);
            chk($sformatf("%s_cos%0d", tag, i), got_cos[i], COS_T[k]);
            chk($sformatf("%s_sin%0d", tag, i), got_sin[i], inv ? -SIN_T[k] : SIN_T[k]);
            chk($sformatf("%s_last%0d", tag, i), got_last[i], (i == 3) ? 1 : 0);
        end
    endtask

    initial begin
        bit found;
        found = 1'b0;

        // reset values
        @(negedge clk);
        chk("rst_valid", tw_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cos", tw_cos, 0);
        chk("rst_sin", tw_sin, 0);
        chk("rst_k", tw_k, 0);
        chk("rst_last", tw_last, 0);
        rst_n = 1'b1;

        // stage 2 forward, cycle by cycle: latency, values, last, done
        @(negedge clk);
        start    = 1'b1;
        stage    = 2'd2;
        inverse  = 1'b0;
        tw_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lat_busy_e0", busy, 1);
        chk("lat_valid_e0", tw_valid, 0);
        @(negedge clk);
        chk("lat_valid_e1", tw_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("a_valid%0d", i), tw_valid, 1);
            chk($sformatf("a_k%0d", i), tw_k, i);
            chk($sformatf("a_cos%0d", i), tw_cos, COS_T[i]);
            chk($sformatf("a_sin%0d", i), tw_sin, SIN_T[i]);
            chk($sformatf("a_last%0d", i), tw_last, (i == 3) ? 1 : 0);
            chk($sformatf("a_done%0d", i), done, 0);
        end
        @(negedge clk);
        chk("a_done_pulse", done, 1);
        chk("a_busy_at_done", busy, 0);
        chk("a_valid_at_done", tw_valid, 0);
        @(negedge clk);
        chk("a_done_cleared", done, 0);

        // stage 2 inverse
        run_seq(2'd2, 1'b1, 1'b0, -1);
        check_seq("inv", 2, 1'b1);

        // stage 1 and stage 0 forward
        run_seq(2'd1, 1'b0, 1'b0, -1);
        check_seq("s1", 1, 1'b0);
        run_seq(2'd0, 1'b0, 1'b0, -1);
        check_seq("s0", 0, 1'b0);

        // back-pressure with a start pulsed mid-sequence
        run_seq(2'd2, 1'b0, 1'b1, 3);
        check_seq("stall", 2, 1'b0);

        // illegal stage
        @(negedge clk);
        start = 1'b1;
        stage = 2'd3;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_cleared", err, 0);
        chk("err_busy2", busy, 0);
        chk("err_no_valid", tw_valid, 0);
        @(negedge clk);
        chk("err_no_valid2", tw_valid, 0);

        // reset during the third word
        @(negedge clk);
        start    = 1'b1;
        stage    = 2'd2;
        inverse  = 1'b0;
        tw_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (tw_valid && tw_k == 2'd2) found = 1'b1;
        end
        chk("ar_third_word", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", tw_valid, 0);
        chk("ar_cos", tw_cos, 0);
        chk("ar_sin", tw_sin, 0);
        chk("ar_k", tw_k, 0);
        chk("ar_last", tw_last, 0);
        chk("ar_busy", busy, 0);
        @(negedge clk);
        chk("ar_no_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_no_done2", done, 0);
        run_seq(2'd2, 1'b0, 1'b0, -1);
        check_seq("after_rst", 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
